// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
//   Framed-packet decoder placed after a UART receiver. Hunts for SYNC_BYTE, then
//   collects LEN, LEN payload bytes and a checksum byte. The checksum byte makes the
//   8-bit wrapping sum of LEN + payload + checksum equal zero. Good payloads are
//   replayed from an internal buffer on a valid/ready stream. Bad frames are dropped
//   and flagged with a one-cycle error pulse.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rx_data, i_rx_en  received byte and its one-cycle strobe
//   o_data, o_valid,    payload stream; o_last marks the final byte;
//   o_last, i_ready     a transfer happens on o_valid & i_ready
//   o_chk_err           checksum mismatch
//   o_len_err           LEN == 0 or LEN > MAX_PAYLOAD
//   o_timeout           inter-byte gap inside a frame exceeded TIMEOUT_CYCLES
//   o_overrun           byte received while draining, dropped
module uart_frame_decoder #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 10_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_chk_err,
  output logic       o_len_err,
  output logic       o_timeout,
  output logic       o_overrun
);

  localparam int unsigned IW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [TW-1:0] TCNT_ONE = TW'(1);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]    r_state;
  logic [IW-1:0] r_len;
  logic [IW-1:0] r_wr_idx;
  logic [IW-1:0] r_rd_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tcnt;
  logic          r_chk_err;
  logic          r_len_err;
  logic          r_timeout;
  logic          r_overrun;
  logic [7:0]    r_buf [MAX_PAYLOAD];

  logic [7:0] w_sum_next;
  logic       w_in_frame;
  logic       w_tmo;
  logic       w_last;
  logic       w_len_bad;

  assign w_sum_next = r_sum + i_rx_data;
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  assign w_len_bad  = (i_rx_data == 8'h00) || (32'(i_rx_data) > MAX_PAYLOAD);

  // r_tcnt is 0 in the cycle after a strobe, so the registered pulse lands exactly
  // TIMEOUT_CYCLES cycles after the last strobe when fired at r_tcnt == TIMEOUT-2.
  // A byte in the firing cycle wins over the timeout.
  assign w_tmo = (TIMEOUT_CYCLES != 0) && w_in_frame && !i_rx_en &&
                 ((32'(r_tcnt) + 32'd2) >= TIMEOUT_CYCLES);

  assign o_valid   = (r_state == S_DRAIN);
  assign w_last    = (r_rd_idx == (r_len - IDX_ONE));
  assign o_last    = o_valid && w_last;
  assign o_data    = o_valid ? r_buf[r_rd_idx[AW-1:0]] : 8'h00;
  assign o_chk_err = r_chk_err;
  assign o_len_err = r_len_err;
  assign o_timeout = r_timeout;
  assign o_overrun = r_overrun;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_HUNT;
      r_len     <= '0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_sum     <= '0;
      r_tcnt    <= '0;
      r_chk_err <= 1'b0;
      r_len_err <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_chk_err <= 1'b0;
      r_len_err <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;

      // Saturate so a disabled timeout never wraps.
      if (!w_in_frame || i_rx_en) begin
        r_tcnt <= '0;
      end else if (r_tcnt != {TW{1'b1}}) begin
        r_tcnt <= r_tcnt + TCNT_ONE;
      end

      if (w_tmo) begin
        r_timeout <= 1'b1;
        r_state   <= S_HUNT;
      end else begin
        case (r_state)
          S_HUNT: begin
            if (i_rx_en && (i_rx_data == SYNC_BYTE)) r_state <= S_LEN;
          end
          S_LEN: begin
            if (i_rx_en) begin
              if (w_len_bad) begin
                r_len_err <= 1'b1;
                r_state   <= S_HUNT;
              end else begin
                r_len    <= i_rx_data[IW-1:0];
                r_sum    <= i_rx_data;
                r_wr_idx <= '0;
                r_state  <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (i_rx_en) begin
              r_sum    <= w_sum_next;
              r_wr_idx <= r_wr_idx + IDX_ONE;
              if (r_wr_idx == (r_len - IDX_ONE)) r_state <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (i_rx_en) begin
              if (w_sum_next == 8'h00) begin
                r_rd_idx <= '0;
                r_state  <= S_DRAIN;
              end else begin
                r_chk_err <= 1'b1;
                r_state   <= S_HUNT;
              end
            end
          end
          S_DRAIN: begin
            if (i_rx_en) r_overrun <= 1'b1;
            if (i_ready) begin
              r_rd_idx <= r_rd_idx + IDX_ONE;
              if (w_last) r_state <= S_HUNT;
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  // Payload storage; contents are only observable in S_DRAIN, so no reset needed.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_PAYLOAD) && i_rx_en) begin
      r_buf[r_wr_idx[AW-1:0]] <= i_rx_data;
    end
  end

endmodule
